// File: rtl/ym3438_dt_sched.sv
// Detune slot scheduler: holds per-slot detune settings, scans slots round-robin,
// arbitrates CPU writes and re-tags delayed detune results. Define YM3438_DT_BYPASS_EN
// to forward a write that lands on the slot being issued in the same cycle.
module ym3438_dt_sched #(
    parameter int SLOTS  = 24,
    parameter int DT_LAT = 1
) (
    input  logic       MCLK,
    input  logic       reset,
    input  logic       run,
    input  logic       slot_en,
    input  logic [4:0] kcode_in,
    input  logic       wr_req,
    input  logic [4:0] wr_slot,
    input  logic [2:0] wr_dt,
    output logic       wr_ack,
    output logic       busy,
    output logic [4:0] slot_out,
    output logic [2:0] dt_out,
    output logic [4:0] kcode_out,
    output logic       sync,
    input  logic [4:0] dt_value,
    input  logic       dt_sign,
    output logic [5:0] offset,
    output logic [4:0] offset_slot,
    output logic       offset_valid
);
    localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        clr_idx_q, clr_idx_d;
    logic [4:0]        slot_q, slot_d;
    logic [2:0]        mem_q [SLOTS];
    logic [2:0]        mem_d [SLOTS];
    logic [DT_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [4:0]        tag_slot_q [DT_LAT];
    logic [4:0]        tag_slot_d [DT_LAT];

    logic       wr_ack_q, wr_ack_d;
    logic [4:0] slot_out_q, slot_out_d;
    logic [2:0] dt_out_q, dt_out_d;
    logic [4:0] kcode_out_q, kcode_out_d;
    logic       sync_q, sync_d;
    logic [5:0] offset_q, offset_d;
    logic [4:0] offset_slot_q, offset_slot_d;
    logic       offset_valid_q, offset_valid_d;

    logic       active_s;
    logic       issue_s;
    logic       commit_s;
    logic       wr_hit_s;
    logic       leave_run_s;
    logic [2:0] rd_dt_s;
    logic [5:0] signed_off_s;

    assign active_s     = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign issue_s      = (state_q == ST_RUN) && slot_en;
    // A held request is committed once: the cycle carrying the ack blocks a second commit.
    assign commit_s     = active_s && wr_req && !wr_ack_q;
    assign wr_hit_s     = commit_s && (wr_slot <= LAST_SLOT);
    assign leave_run_s  = (state_q == ST_RUN) && !run;
    assign signed_off_s = dt_sign ? (6'd0 - {1'b0, dt_value}) : {1'b0, dt_value};

`ifdef YM3438_DT_BYPASS_EN
    assign rd_dt_s = (wr_hit_s && (wr_slot == slot_q)) ? wr_dt : mem_q[slot_q];
`else
    assign rd_dt_s = mem_q[slot_q];
`endif

    // Mode sequencing: clear sweep after reset, then idle/run under control of run.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLR: begin
                if (clr_idx_q == LAST_SLOT) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = 5'd0;
                end else begin
                    state_d   = ST_CLR;
                    clr_idx_d = clr_idx_q + 5'd1;
                end
            end
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_CLR;
                clr_idx_d = 5'd0;
            end
        endcase
    end

    // Detune memory update: sweep clear has priority, CPU writes only outside the sweep.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            mem_d[i] = ((state_q == ST_CLR) && (clr_idx_q == 5'(i))) ? 3'd0 :
                       (wr_hit_s && (wr_slot == 5'(i)))              ? wr_dt :
                                                                        mem_q[i];
        end
    end

    // Slot issue towards the detune unit and slot counter advance.
    always_comb begin
        slot_d      = slot_q;
        slot_out_d  = slot_out_q;
        dt_out_d    = dt_out_q;
        kcode_out_d = kcode_out_q;
        sync_d      = 1'b0;
        wr_ack_d    = commit_s;
        if (issue_s) begin
            slot_out_d  = slot_q;
            dt_out_d    = rd_dt_s;
            kcode_out_d = kcode_in;
            sync_d      = (slot_q == 5'd0);
            slot_d      = (slot_q == LAST_SLOT) ? 5'd0 : (slot_q + 5'd1);
        end else begin
            sync_d      = 1'b0;
        end
    end

    // Tag pipeline re-aligns the detune result with the slot it was issued for.
    always_comb begin
        tag_vld_d      = tag_vld_q;
        for (int i = 0; i < DT_LAT; i++) begin
            tag_slot_d[i] = tag_slot_q[i];
        end
        offset_d       = offset_q;
        offset_slot_d  = offset_slot_q;
        offset_valid_d = 1'b0;
        if (issue_s) begin
            if (tag_vld_q[DT_LAT-1]) begin
                offset_d       = signed_off_s;
                offset_slot_d  = tag_slot_q[DT_LAT-1];
                offset_valid_d = 1'b1;
            end else begin
                offset_valid_d = 1'b0;
            end
            for (int i = DT_LAT - 1; i > 0; i--) begin
                tag_vld_d[i]  = tag_vld_q[i-1];
                tag_slot_d[i] = tag_slot_q[i-1];
            end
            tag_vld_d[0]  = 1'b1;
            tag_slot_d[0] = slot_q;
        end else begin
            offset_valid_d = 1'b0;
        end
        if (leave_run_s) begin
            tag_vld_d = {DT_LAT{1'b0}};
        end else begin
            tag_vld_d = tag_vld_d;
        end
    end

    // Control, tag and output registers.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            state_q        <= ST_CLR;
            clr_idx_q      <= 5'd0;
            slot_q         <= 5'd0;
            tag_vld_q      <= {DT_LAT{1'b0}};
            for (int i = 0; i < DT_LAT; i++) begin
                tag_slot_q[i] <= 5'd0;
            end
            wr_ack_q       <= 1'b0;
            slot_out_q     <= 5'd0;
            dt_out_q       <= 3'd0;
            kcode_out_q    <= 5'd0;
            sync_q         <= 1'b0;
            offset_q       <= 6'd0;
            offset_slot_q  <= 5'd0;
            offset_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            slot_q         <= slot_d;
            tag_vld_q      <= tag_vld_d;
            for (int i = 0; i < DT_LAT; i++) begin
                tag_slot_q[i] <= tag_slot_d[i];
            end
            wr_ack_q       <= wr_ack_d;
            slot_out_q     <= slot_out_d;
            dt_out_q       <= dt_out_d;
            kcode_out_q    <= kcode_out_d;
            sync_q         <= sync_d;
            offset_q       <= offset_d;
            offset_slot_q  <= offset_slot_d;
            offset_valid_q <= offset_valid_d;
        end
    end

    // Detune storage; its contents are initialised by the clear sweep, not by reset.
    always_ff @(posedge MCLK) begin
        for (int i = 0; i < SLOTS; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign busy         = (state_q == ST_CLR);
    assign wr_ack       = wr_ack_q;
    assign slot_out     = slot_out_q;
    assign dt_out       = dt_out_q;
    assign kcode_out    = kcode_out_q;
    assign sync         = sync_q;
    assign offset       = offset_q;
    assign offset_slot  = offset_slot_q;
    assign offset_valid = offset_valid_q;

endmodule

// File: tb/tb_ym3438_dt_sched.sv
// Bench for ym3438_dt_sched: directed scenarios plus random traffic checked every
// cycle against a slot/queue-level reference model (DT_LAT=2).
module tb_ym3438_dt_sched;
    localparam int SLOTS  = 24;
    localparam int DT_LAT = 2;

    logic       MCLK = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       slot_en = 1'b0;
    logic [4:0] kcode_in = 5'd0;
    logic       wr_req = 1'b0;
    logic [4:0] wr_slot = 5'd0;
    logic [2:0] wr_dt = 3'd0;
    logic [4:0] dt_value = 5'd0;
    logic       dt_sign = 1'b0;
    logic       wr_ack, busy, sync, offset_valid;
    logic [4:0] slot_out, kcode_out, offset_slot;
    logic [2:0] dt_out;
    logic [5:0] offset;

    always #5 MCLK = ~MCLK;

    ym3438_dt_sched #(.SLOTS(SLOTS), .DT_LAT(DT_LAT)) dut (
        .MCLK(MCLK), .reset(reset), .run(run), .slot_en(slot_en), .kcode_in(kcode_in),
        .wr_req(wr_req), .wr_slot(wr_slot), .wr_dt(wr_dt), .wr_ack(wr_ack), .busy(busy),
        .slot_out(slot_out), .dt_out(dt_out), .kcode_out(kcode_out), .sync(sync),
        .dt_value(dt_value), .dt_sign(dt_sign), .offset(offset), .offset_slot(offset_slot),
        .offset_valid(offset_valid)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit hold_dt = 1'b0;

    // Reference model: memory contents, sweep countdown, scan position, in-flight slots.
    logic [2:0] m_mem [SLOTS];
    int         m_clr_left;
    bit         m_running;
    int         m_slot;
    int         m_q [$];
    logic [4:0] e_slot_out, e_kcode, e_oslot;
    logic [2:0] e_dt;
    logic [5:0] e_off;
    logic       e_sync, e_ovalid, e_ack, e_busy;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("busy", 8'(busy), 8'(e_busy));
        chk("wr_ack", 8'(wr_ack), 8'(e_ack));
        chk("slot_out", 8'(slot_out), 8'(e_slot_out));
        chk("dt_out", 8'(dt_out), 8'(e_dt));
        chk("kcode_out", 8'(kcode_out), 8'(e_kcode));
        chk("sync", 8'(sync), 8'(e_sync));
        chk("offset", 8'(offset), 8'(e_off));
        chk("offset_slot", 8'(offset_slot), 8'(e_oslot));
        chk("offset_valid", 8'(offset_valid), 8'(e_ovalid));
    endtask

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) m_mem[i] = 3'd0;
        m_clr_left = SLOTS;
        m_running  = 1'b0;
        m_slot     = 0;
        m_q.delete();
        e_slot_out = 5'd0; e_kcode = 5'd0; e_oslot = 5'd0; e_dt = 3'd0; e_off = 6'd0;
        e_sync = 1'b0; e_ovalid = 1'b0; e_ack = 1'b0; e_busy = 1'b1;
    endtask

    task automatic model_edge();
        bit commit;
        int v;
        e_sync   = 1'b0;
        e_ovalid = 1'b0;
        if (m_clr_left > 0) begin
            m_clr_left--;
            e_ack = 1'b0;
        end else begin
            commit = wr_req && !e_ack;
            if (m_running && slot_en) begin
                e_slot_out = 5'(m_slot);
                e_dt       = m_mem[m_slot];
`ifdef YM3438_DT_BYPASS_EN
                if (commit && int'(wr_slot) == m_slot) e_dt = wr_dt;
`endif
                e_kcode = kcode_in;
                e_sync  = (m_slot == 0);
                if (m_q.size() == DT_LAT) begin
                    e_oslot  = 5'(m_q.pop_front());
                    e_ovalid = 1'b1;
                    v        = dt_sign ? -int'(dt_value) : int'(dt_value);
                    e_off    = 6'(v);
                end
                m_q.push_back(m_slot);
                m_slot = (m_slot + 1) % SLOTS;
            end
            if (commit && int'(wr_slot) < SLOTS) m_mem[wr_slot] = wr_dt;
            e_ack = commit;
            if (m_running && !run) begin
                m_running = 1'b0;
                m_q.delete();
            end else if (!m_running && run) begin
                m_running = 1'b1;
            end
        end
        e_busy = (m_clr_left > 0);
    endtask

    task automatic tick();
        @(posedge MCLK);
        model_edge();
        #1;
        check_all();
        if (e_ack) wr_req = 1'b0;
        kcode_in = 5'($urandom_range(0, 31));
        if (!hold_dt) begin
            dt_value = 5'($urandom_range(0, 31));
            dt_sign  = 1'($urandom_range(0, 1));
        end
    endtask

    // Strobe every other cycle until the next slot to issue is target (bounded).
    task automatic advance_to(input int target);
        int i = 0;
        do begin
            slot_en = 1'b1; tick();
            slot_en = 1'b0; tick();
            i++;
        end while (m_slot != target && i < 100);
        chk("reach_slot", 8'(slot_out), 8'((target + SLOTS - 1) % SLOTS));
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        @(posedge MCLK); #1;
        check_all();
        reset = 1'b0;
        // Write requested during the clear sweep must wait for it to finish.
        wr_req = 1'b1; wr_slot = 5'd5; wr_dt = 3'b101;
        for (int i = 1; i <= SLOTS; i++) begin
            tick();
            chk("busy_sweep", 8'(busy), 8'(i < SLOTS));
            chk("ack_stall", 8'(wr_ack), 8'd0);
        end
        tick();
        chk("ack_c25", 8'(wr_ack), 8'd1);
        tick();

        // Run with a strobe every fourth cycle for two rotations.
        run = 1'b1;
        for (int i = 0; i < 200; i++) begin
            slot_en = (i % 4 == 3);
            tick();
            if (slot_en) chk("dt_slot5", 8'(dt_out), 8'((slot_out == 5'd5) ? 5 : 0));
        end
        slot_en = 1'b0;

        // Detune unit reporting -7, then a negative zero.
        hold_dt = 1'b1; dt_value = 5'd7; dt_sign = 1'b1;
        for (int i = 0; i < 8; i++) begin
            slot_en = 1'b1; tick(); slot_en = 1'b0;
            chk("off_m7_valid", 8'(offset_valid), 8'd1);
            chk("off_m7", 8'(offset), 8'h39);
            chk("off_m7_slot", 8'(offset_slot), 8'((int'(slot_out) + SLOTS - DT_LAT) % SLOTS));
            tick();
        end
        dt_value = 5'd0;
        slot_en = 1'b1; tick(); slot_en = 1'b0;
        chk("off_negzero", 8'(offset), 8'd0);
        tick();
        hold_dt = 1'b0;

        // Write to slot 9 in the very cycle slot 9 is issued.
        advance_to(9);
        slot_en = 1'b1; wr_req = 1'b1; wr_slot = 5'd9; wr_dt = 3'd4;
        tick();
        slot_en = 1'b0;
`ifdef YM3438_DT_BYPASS_EN
        chk("same_cycle_dt", 8'(dt_out), 8'd4);
`else
        chk("same_cycle_dt", 8'(dt_out), 8'd0);
`endif
        chk("same_cycle_ack", 8'(wr_ack), 8'd1);
        tick();
        advance_to(9);
        slot_en = 1'b1; tick(); slot_en = 1'b0;
        chk("next_rot_dt", 8'(dt_out), 8'd4);
        tick();

        // Pause at slot 12: no results in the gap, resume at the held slot.
        advance_to(12);
        run = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            slot_en = (i % 2 == 0);
            tick();
            chk("gap_ovalid", 8'(offset_valid), 8'd0);
        end
        slot_en = 1'b0;
        run = 1'b1;
        tick();
        slot_en = 1'b1; tick(); slot_en = 1'b0;
        chk("resume_slot", 8'(slot_out), 8'd12);
        tick();

        // Random traffic: strobes, writes (including out-of-range slots), run toggles.
        for (int i = 0; i < 800; i++) begin
            slot_en = !slot_en && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 49) == 0) run = !run;
            if (!wr_req && $urandom_range(0, 7) == 0) begin
                wr_req  = 1'b1;
                wr_slot = 5'($urandom_range(0, 31));
                wr_dt   = 3'($urandom_range(0, 7));
            end
            tick();
        end
        slot_en = 1'b0; run = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Reset in the middle of a pending write while slot 17 is being scanned.
        advance_to(17);
        slot_en = 1'b1; tick(); slot_en = 1'b0;
        wr_req = 1'b1; wr_slot = 5'd3; wr_dt = 3'd6;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_slot_out", 8'(slot_out), 8'd0);
        chk("rst_busy", 8'(busy), 8'd1);
        wr_req = 1'b0;
        @(posedge MCLK); #1;
        check_all();
        reset = 1'b0;
        for (int i = 0; i < SLOTS + 2; i++) tick();
        advance_to(3);
        slot_en = 1'b1; tick(); slot_en = 1'b0;
        chk("lost_write", 8'(dt_out), 8'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
